// File: rtl/dct_mac_dsp_pkg.sv
// Shared encoder constants and the control payload carried down the DSP slice pipeline.
package dct_mac_dsp_pkg;

    localparam int unsigned DCT_AW          = 9;
    localparam int unsigned DCT_BW          = 8;
    localparam int unsigned DCT_PW          = 24;
    localparam int unsigned DCT_LAT         = 4;
    localparam int unsigned DCT_LEVEL_SHIFT = 128;

    // Per-sample accumulator control, delayed alongside the datapath.
    typedef struct packed {
        logic load;
        logic clear;
    } dsp_ctrl_t;

endpackage

// File: rtl/dsp_delay_line.sv
// Generic single-bit shift register; exposes every tap.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : bit to delay
//   q_o[i]     : d_i delayed i+1 edges
module dsp_delay_line #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_i,
    output logic [DEPTH-1:0] q_o
);

    logic [DEPTH-1:0] q_q;
    logic [DEPTH-1:0] q_d;

    always_comb begin
        q_d = {q_q[DEPTH-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/dct_mac_dsp.sv
// Pipelined pre-add / multiply / accumulate slice: P accumulates (A - D) * B,
// seeded from 0 (clear) or from rrC (load). Four-edge latency, never stalls.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load, clear        : accumulator seed select for this sample (clear wins)
//   idelay             : strobe carried through the delay line
//   A, D               : unsigned pixel and level-shift subtrahend
//   B                  : signed coefficient
//   rrC                : signed seed, taken two edges after a load sample
//   P                  : signed accumulator
//   odelay_pre1/odelay : idelay delayed LAT-1 / LAT edges
module dct_mac_dsp
    import dct_mac_dsp_pkg::*;
#(
    parameter int unsigned AW  = DCT_AW,
    parameter int unsigned BW  = DCT_BW,
    parameter int unsigned PW  = DCT_PW,
    parameter int unsigned LAT = DCT_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 idelay,
    input  logic        [AW-1:0] A,
    input  logic signed [BW-1:0] B,
    input  logic signed [PW-1:0] rrC,
    input  logic        [AW-1:0] D,
    output logic signed [PW-1:0] P,
    output logic                 odelay_pre1,
    output logic                 odelay
);

    localparam int unsigned ADW = AW + 1;
    localparam int unsigned MW  = ADW + BW;

    logic        [AW-1:0]  a_q, d_q;
    logic signed [BW-1:0]  b1_q, b2_q;
    dsp_ctrl_t             ctrl1_q, ctrl2_q, ctrl3_q;
    logic signed [ADW-1:0] ad_q, ad_d;
    logic signed [MW-1:0]  m_q, m_d;
    logic signed [PW-1:0]  c_q, p_q, p_d, p_base;
    logic        [LAT-1:0] dly;

    // Pre-add on zero-extended operands, full-precision multiply, seeded accumulate.
    always_comb begin
        ad_d   = ADW'(a_q) - ADW'(d_q);
        m_d    = MW'(ad_q) * MW'(b2_q);
        p_base = p_q;
        if (ctrl3_q.clear)     p_base = '0;
        else if (ctrl3_q.load) p_base = c_q;
        p_d    = p_base + PW'(m_q);
    end

    // Stages 1-4; rrC is captured in the same edge that registers the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            d_q     <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            ctrl1_q <= '0;
            ctrl2_q <= '0;
            ctrl3_q <= '0;
            ad_q    <= '0;
            m_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
        end else begin
            a_q     <= A;
            d_q     <= D;
            b1_q    <= B;
            ctrl1_q <= '{load: load, clear: clear};
            ad_q    <= ad_d;
            b2_q    <= b1_q;
            ctrl2_q <= ctrl1_q;
            m_q     <= m_d;
            c_q     <= rrC;
            ctrl3_q <= ctrl2_q;
            p_q     <= p_d;
        end
    end

    // Strobe taps; the datapath itself is a fixed four-stage pipe.
    dsp_delay_line #(
        .DEPTH (LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (idelay),
        .q_o   (dly)
    );

    assign P           = p_q;
    assign odelay      = dly[LAT-1];
    assign odelay_pre1 = dly[LAT-2];

endmodule

// File: tb/tb_dct_mac_dsp.sv
module tb_dct_mac_dsp;
    import dct_mac_dsp_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               load, clear, idelay;
    logic        [8:0]  A, D;
    logic signed [7:0]  B;
    logic signed [23:0] rrC;
    logic signed [23:0] P;
    logic               odelay_pre1, odelay;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: per-cycle sample history since the last reset release
    int  k;
    int  ha[1024], hd[1024], hb[1024], hrc[1024];
    bit  hld[1024], hclr[1024], hidl[1024];
    logic signed [23:0] acc;
    logic signed [23:0] last_p;

    always #5 clk = ~clk;

    dct_mac_dsp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .clear       (clear),
        .idelay      (idelay),
        .A           (A),
        .B           (B),
        .rrC         (rrC),
        .D           (D),
        .P           (P),
        .odelay_pre1 (odelay_pre1),
        .odelay      (odelay)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%06h) required %0d (0x%06h)",
                   tag, $signed(obs), obs, $signed(exp_v), exp_v);
        end
    endtask

    // One cycle: drive sample, advance model, compare mid-cycle, move past the edge.
    task automatic cyc(input int a, input int d, input int b, input bit ld,
                       input bit clr, input bit idl, input int rc);
        int m;
        bit exp_od, exp_pre;
        A = 9'(a); D = 9'(d); B = 8'(b); load = ld; clear = clr; idelay = idl; rrC = 24'(rc);
        ha[k] = a; hd[k] = d; hb[k] = b; hld[k] = ld; hclr[k] = clr; hidl[k] = idl; hrc[k] = rc;
        if (k >= 4) begin
            m = (ha[k-4] - hd[k-4]) * hb[k-4];
            if (hclr[k-4])     acc = 24'(m);
            else if (hld[k-4]) acc = 24'(hrc[k-2] + m);
            else               acc = 24'(acc + m);
        end
        exp_od  = (k >= 4) ? hidl[k-4] : 1'b0;
        exp_pre = (k >= 3) ? hidl[k-3] : 1'b0;
        @(negedge clk);
        chk($sformatf("P[c%0d]", k), P, acc);
        chk($sformatf("odelay[c%0d]", k), 24'(odelay), 24'(exp_od));
        chk($sformatf("odelay_pre1[c%0d]", k), 24'(odelay_pre1), 24'(exp_pre));
        last_p = P;
        k++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(DCT_LEVEL_SHIFT, DCT_LEVEL_SHIFT, 0, 0, 0, 0, -7);
    endtask

    // 8-sample row of A=a, D=128, B=b; first sample carries ld/clr, last carries idelay,
    // seed value supplied in the third cycle of the row.
    task automatic row(input int a, input int b, input bit ld, input bit clr, input int seed);
        for (int i = 0; i < 8; i++)
            cyc(a, DCT_LEVEL_SHIFT, b, (i == 0) ? ld : 1'b0, (i == 0) ? clr : 1'b0,
                i == 7, (i == 2) ? seed : -7);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        k = 0;
        acc = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 0; clear = 0; idelay = 0;
        A = '0; D = '0; B = '0; rrC = '0;
        k = 0; acc = '0; last_p = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset_P", P, 24'd0);
        chk("reset_odelay", 24'(odelay), 24'd0);
        chk("reset_pre1", 24'(odelay_pre1), 24'd0);
        @(posedge clk); #1;
        release_reset();

        // level shift: 128-128 -> 0
        cyc(128, 128, 100, 0, 1, 0, -7);
        idle(4);
        chk("level_shift", last_p, 24'd0);

        // extremes
        cyc(255, 128, -128, 0, 1, 0, -7);
        idle(4);
        chk("extreme_pos_a", last_p, -24'sd16256);
        cyc(0, 128, -128, 0, 1, 0, -7);
        idle(4);
        chk("extreme_zero_a", last_p, 24'sd16384);

        // row accumulation with clear
        row(200, 10, 0, 1, -7);
        idle(4);
        chk("row_clear", last_p, 24'sd5760);

        // load seeding, then clear overriding load
        row(200, 10, 1, 0, 1000);
        idle(4);
        chk("row_load", last_p, 24'sd6760);
        row(200, 10, 1, 1, 1000);
        idle(4);
        chk("row_clear_over_load", last_p, 24'sd5760);

        // back-to-back rows
        row(200, 10, 0, 1, -7);
        row(129, -1, 1, 0, 5760);
        idle(4);
        chk("back_to_back", last_p, 24'sd5752);

        // async reset in mid-row, between edges
        cyc(200, 128, 10, 0, 1, 0, -7);
        cyc(200, 128, 10, 0, 0, 0, -7);
        cyc(200, 128, 10, 0, 0, 1, -7);
        cyc(200, 128, 10, 0, 0, 1, -7);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_P", P, 24'd0);
        chk("async_odelay", 24'(odelay), 24'd0);
        chk("async_pre1", 24'(odelay_pre1), 24'd0);
        @(posedge clk); @(posedge clk); #1;
        release_reset();
        row(200, 10, 0, 1, -7);
        idle(4);
        chk("post_reset_row", last_p, 24'sd5760);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(int'($urandom_range(511)),
                ($urandom_range(3) == 0) ? int'($urandom_range(511)) : 128,
                int'($urandom_range(255)) - 128,
                $urandom_range(7) == 0, $urandom_range(9) == 0, 1'($urandom),
                int'($urandom_range(16777215)) - 8388608);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
